// File: rtl/ahb_flash_writer_spi_if.sv
// AHB-Lite slave-side bus bundle for the flash writer.
// master drives HSEL/HADDR/HTRANS/HWRITE/HREADY/HWDATA/HSIZE; slave returns HREADYOUT/HRDATA.
interface ahb_flash_writer_spi_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE,
    output HREADY, HWDATA, HSIZE,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE,
    input  HREADY, HWDATA, HSIZE,
    output HREADYOUT, HRDATA
  );
endinterface

// File: rtl/ahb_flash_writer_spi.sv
// AHB-Lite flash writer: SPI shift engine that takes over the QSPI pins from the reader when unlocked.
// Ports: HCLK/HRESETn, AHB slave bus, fr_* reader side, fm_* flash pins. Option: FW_AUTO_CE_EN.
module ahb_flash_writer_spi #(
  parameter int              DIV_W   = 8,
  parameter logic [DIV_W-1:0] DIV_RST = 1,
  parameter int              NUM_CS  = 1,
  parameter logic [31:0]     ID_VAL  = 32'hABCD0002
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahb_flash_writer_spi_if.slave bus,
  input  logic                fr_sck,
  input  logic                fr_ce_n,
  output logic [3:0]          fr_din,
  input  logic [3:0]          fr_dout,
  input  logic                fr_douten,
  output logic                fm_sck,
  output logic [NUM_CS-1:0]   fm_ce_n,
  input  logic [3:0]          fm_din,
  output logic [3:0]          fm_dout,
  output logic [3:0]          fm_douten
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH
  } state_t;

  state_t r_state, w_state_nxt;

  logic             r_act, r_wr;
  logic [7:0]       r_addr;
  logic             r_we;
  logic [1:0]       r_ctrl;
  logic [DIV_W-1:0] r_div;
  logic [NUM_CS-1:0] r_ce;
  logic [7:0]       r_rx;
  logic             r_ovr;

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_q;
  logic             r_quad, r_qin;
  logic [2:0]       r_beat;
  logic [7:0]       r_tx;
  logic [7:0]       r_rxsh;
  logic             r_sck;
`ifdef FW_AUTO_CE_EN
  logic             r_last;
`endif

  logic w_wr, w_wr_we, w_wr_ctrl, w_wr_div;
  logic w_wr_tx, w_wr_st, w_wr_ce;
  logic w_we_nxt, w_busy, w_start, w_ovr_set;
  logic w_to_high, w_to_low, w_done, w_abort;
  logic [3:0] w_eng_dout, w_eng_oe;
  logic [NUM_CS-1:0] w_byp_ce;
  logic w_unused;

  assign w_unused = ^{bus.HSIZE, bus.HADDR[31:8],
                      bus.HTRANS[0], bus.HWDATA};

  // Address phase capture; no wait states.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_act  <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= 8'h00;
    end else if (bus.HREADY) begin
      r_act  <= bus.HSEL & bus.HTRANS[1];
      r_wr   <= bus.HWRITE;
      r_addr <= bus.HADDR[7:0];
    end
  end

  assign w_wr      = r_act & r_wr;
  assign w_wr_we   = w_wr & (r_addr == 8'h00);
  assign w_wr_ctrl = w_wr & (r_addr == 8'h04);
  assign w_wr_div  = w_wr & (r_addr == 8'h08);
  assign w_wr_tx   = w_wr & (r_addr == 8'h0C);
  assign w_wr_st   = w_wr & (r_addr == 8'h14);
  assign w_wr_ce   = w_wr & (r_addr == 8'h1C);

  assign w_we_nxt = (w_wr_we &&
                     bus.HWDATA[31:8] == 24'hA5A855)
                    ? bus.HWDATA[0] : r_we;
  assign w_busy    = (r_state != S_IDLE);
  assign w_start   = w_wr_tx & r_we & ~w_busy;
  assign w_ovr_set = w_wr_tx & r_we & w_busy;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_to_high   = 1'b0;
    w_to_low    = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_LOW;
      S_LOW: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_HIGH;
          w_to_high   = 1'b1;
        end
      end
      S_HIGH: begin
        if (r_cnt == '0) begin
          if (r_beat != 3'd0) begin
            w_state_nxt = S_LOW;
            w_to_low    = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Losing the unlock kills any byte in flight.
    if (w_busy && !w_we_nxt) begin
      w_state_nxt = S_IDLE;
      w_to_high   = 1'b0;
      w_to_low    = 1'b0;
      w_done      = 1'b0;
      w_abort     = 1'b1;
    end
  end

  // Shift engine datapath; mode and divider frozen at start.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_cnt   <= '0;
      r_div_q <= '0;
      r_quad  <= 1'b0;
      r_qin   <= 1'b0;
      r_beat  <= 3'd0;
      r_tx    <= 8'h00;
      r_rxsh  <= 8'h00;
      r_rx    <= 8'h00;
      r_sck   <= 1'b0;
    end else if (w_start) begin
      r_cnt   <= r_div;
      r_div_q <= r_div;
      r_quad  <= r_ctrl[0];
      r_qin   <= r_ctrl[1];
      r_beat  <= r_ctrl[0] ? 3'd1 : 3'd7;
      r_tx    <= bus.HWDATA[7:0];
      r_sck   <= 1'b0;
    end else if (w_abort) begin
      r_sck   <= 1'b0;
    end else if (w_to_high) begin
      r_cnt   <= r_div_q;
      r_sck   <= 1'b1;
      r_rxsh  <= r_quad ? {r_rxsh[3:0], fm_din}
                        : {r_rxsh[6:0], fm_din[1]};
    end else if (w_to_low) begin
      r_cnt   <= r_div_q;
      r_sck   <= 1'b0;
      r_beat  <= r_beat - 3'd1;
      r_tx    <= r_quad ? {r_tx[3:0], 4'h0}
                        : {r_tx[6:0], 1'b0};
    end else if (w_done) begin
      r_sck   <= 1'b0;
      r_rx    <= r_rxsh;
    end else if (w_busy) begin
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_we   <= 1'b0;
      r_ctrl <= 2'b00;
      r_div  <= DIV_RST;
      r_ce   <= '1;
      r_ovr  <= 1'b0;
`ifdef FW_AUTO_CE_EN
      r_last <= 1'b0;
`endif
    end else begin
      r_we <= w_we_nxt;
      if (w_wr_ctrl) r_ctrl <= bus.HWDATA[1:0];
      if (w_wr_div)  r_div  <= bus.HWDATA[DIV_W-1:0];
      if (w_wr_ce)   r_ce   <= bus.HWDATA[NUM_CS-1:0];
`ifdef FW_AUTO_CE_EN
      if (w_start) r_last <= bus.HWDATA[8];
      if (w_done && r_last) r_ce <= '1;
`endif
      // Set has priority over a same-cycle clear.
      if (w_wr_st && bus.HWDATA[1]) r_ovr <= 1'b0;
      if (w_ovr_set) r_ovr <= 1'b1;
    end
  end

  always_comb begin
    bus.HRDATA = 32'h0;
    case (r_addr)
      8'h00: bus.HRDATA = {31'h0, r_we};
      8'h04: bus.HRDATA = {30'h0, r_ctrl};
      8'h08: bus.HRDATA = 32'(r_div);
      8'h10: bus.HRDATA = {24'h0, r_rx};
      8'h14: bus.HRDATA = {30'h0, r_ovr, w_busy};
      8'h18: bus.HRDATA = ID_VAL;
      8'h1C: bus.HRDATA = 32'(r_ce);
      default: bus.HRDATA = 32'h0;
    endcase
  end

  assign bus.HREADYOUT = 1'b1;

  // Single mode keeps WP#/HOLD# driven high.
  always_comb begin
    w_eng_dout = 4'h0;
    w_eng_oe   = 4'h0;
    if (w_busy) begin
      if (r_quad) begin
        w_eng_dout = r_tx[7:4];
        w_eng_oe   = r_qin ? 4'b0000 : 4'b1111;
      end else begin
        w_eng_dout = {2'b11, 1'b0, r_tx[7]};
        w_eng_oe   = 4'b1101;
      end
    end
  end

  always_comb begin
    w_byp_ce    = '1;
    w_byp_ce[0] = fr_ce_n;
  end

  assign fr_din    = fm_din;
  assign fm_sck    = r_we ? r_sck : fr_sck;
  assign fm_ce_n   = r_we ? r_ce : w_byp_ce;
  assign fm_dout   = r_we ? w_eng_dout : fr_dout;
  assign fm_douten = r_we ? w_eng_oe : {4{fr_douten}};

endmodule
